aim_arrow_ctrl: RTL and testbench

- Parametrised successor to the bowling aim-arrow mux.
- Decodes a PS/2 scan-code byte stream, including break (F0) and extended (E0) prefixes.
- Tracks held left/right keys and moves the aim position one step per press, then auto-repeats while a key is held.
- Supports saturate or wrap-around modes, lock during a throw, and recenter; x_pos feeds the lane renderer and the ball-launch logic.

---
 rtl/aim_arrow_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_aim_arrow_ctrl.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/aim_arrow_ctrl.sv
// -----------------------------------------------------------------------------
// aim_arrow_ctrl
//   Aim-position controller for the bowling lane. Decodes the PS/2 scan-code
//   stream (including F0 break and E0 extended prefixes), tracks which of the
//   left/right keys are held, steps the aim position once per press and then
//   auto-repeats on the tick timebase while exactly one key stays held.
//   Ends either saturate or wrap depending on WRAP. lock freezes the position
//   while the ball is in flight; recenter snaps it back to CENTER.
//
// Ports
//   CLOCK_50    in   system clock, all logic on posedge
//   reset       in   synchronous active-high reset
//   scan_code   in   PS/2 byte from the keyboard receiver
//   scan_valid  in   one-cycle strobe qualifying scan_code
//   tick        in   one-cycle auto-repeat timebase strobe
//   lock        in   high freezes x_pos
//   recenter    in   one-cycle pulse forcing x_pos to CENTER
//   x_pos       out  current aim position, 0..NUM_POS-1
//   at_left     out  x_pos == 0
//   at_right    out  x_pos == NUM_POS-1
//   moved       out  one-cycle pulse after x_pos changed by a step
//   held        out  {right_held, left_held}
// -----------------------------------------------------------------------------
module aim_arrow_ctrl #(
    parameter int         NUM_POS      = 10,
    parameter int         POS_W        = 4,
    parameter int         CENTER       = 5,
    parameter logic [7:0] LEFT_CODE    = 8'h1C,
    parameter logic [7:0] RIGHT_CODE   = 8'h23,
    parameter int         REPEAT_DELAY = 8,
    parameter int         REPEAT_RATE  = 3,
    parameter int         WRAP         = 0
) (
    input  logic             CLOCK_50,
    input  logic             reset,
    input  logic [7:0]       scan_code,
    input  logic             scan_valid,
    input  logic             tick,
    input  logic             lock,
    input  logic             recenter,
    output logic [POS_W-1:0] x_pos,
    output logic             at_left,
    output logic             at_right,
    output logic             moved,
    output logic [1:0]       held
);

    localparam logic [POS_W-1:0] LAST_POS   = POS_W'(NUM_POS - 1);
    localparam logic [POS_W-1:0] CENTER_POS = POS_W'(CENTER);
    localparam int               CNT_MAX    = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int               CNT_W      = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] DELAY_LD   = CNT_W'(REPEAT_DELAY);
    localparam logic [CNT_W-1:0] RATE_LD    = CNT_W'(REPEAT_RATE);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    // One step left or right, saturating or wrapping at the ends. The end
    // positions are tested before any add/subtract so no intermediate value
    // ever leaves the 0..NUM_POS-1 range.
    function automatic logic [POS_W-1:0] step_pos(input logic [POS_W-1:0] x,
                                                  input logic             go_right);
        logic [POS_W-1:0] r;
        if (go_right) begin
            if (x == LAST_POS) r = (WRAP != 0) ? '0 : x;
            else               r = x + POS_W'(1);
        end else begin
            if (x == '0)       r = (WRAP != 0) ? LAST_POS : x;
            else               r = x - POS_W'(1);
        end
        return r;
    endfunction

    logic             brk_pend, ext_pend;
    logic [CNT_W-1:0] rep_cnt;

    logic             brk_nxt, ext_nxt;
    logic [1:0]       held_nxt;
    logic             press_l, press_r;
    logic             one_held;
    logic             do_step;
    logic [POS_W-1:0] x_step;
    logic [POS_W-1:0] x_nxt;
    logic [CNT_W-1:0] rep_nxt;
    logic             moved_nxt;

    // Scan-code decoder: prefixes only arm flags; any other byte consumes them.
    always_comb begin
        brk_nxt  = brk_pend;
        ext_nxt  = ext_pend;
        held_nxt = held;
        press_l  = 1'b0;
        press_r  = 1'b0;
        if (scan_valid) begin
            if (scan_code == 8'hF0) begin
                brk_nxt = 1'b1;
            end else if (scan_code == 8'hE0) begin
                ext_nxt = 1'b1;
            end else begin
                brk_nxt = 1'b0;
                ext_nxt = 1'b0;
                if (!ext_pend) begin
                    if (brk_pend) begin
                        if (scan_code == LEFT_CODE)  held_nxt[0] = 1'b0;
                        if (scan_code == RIGHT_CODE) held_nxt[1] = 1'b0;
                    end else begin
                        // Typematic re-sends of a held key are not new presses.
                        if (scan_code == LEFT_CODE && !held[0]) begin
                            held_nxt[0] = 1'b1;
                            press_l     = 1'b1;
                        end
                        if (scan_code == RIGHT_CODE && !held[1]) begin
                            held_nxt[1] = 1'b1;
                            press_r     = 1'b1;
                        end
                    end
                end
            end
        end
    end

    // With exactly one key held, its bit alone gives the step direction.
    assign one_held = held_nxt[0] ^ held_nxt[1];
    assign x_step   = step_pos(x_pos, held_nxt[1]);

    // Step / auto-repeat decision. A press outranks a coincident tick, and a
    // recenter outranks any step in the same cycle.
    always_comb begin
        x_nxt     = x_pos;
        rep_nxt   = rep_cnt;
        moved_nxt = 1'b0;
        do_step   = 1'b0;
        if (lock || !one_held) begin
            rep_nxt = '0;
        end else if (press_l || press_r) begin
            rep_nxt = DELAY_LD;
            do_step = 1'b1;
        end else if (tick) begin
            if (rep_cnt == CNT_ONE) begin
                rep_nxt = RATE_LD;
                do_step = 1'b1;
            end else if (rep_cnt != '0) begin
                rep_nxt = rep_cnt - CNT_ONE;
            end else begin
                // Counter idle with one key held (after lock or a release of
                // the other key): restart the delay without stepping.
                rep_nxt = DELAY_LD;
            end
        end
        if (do_step) begin
            x_nxt     = x_step;
            moved_nxt = (x_step != x_pos);
        end
        if (recenter) begin
            x_nxt     = CENTER_POS;
            moved_nxt = 1'b0;
            if (!lock && one_held) rep_nxt = DELAY_LD;
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            x_pos    <= CENTER_POS;
            held     <= 2'b00;
            brk_pend <= 1'b0;
            ext_pend <= 1'b0;
            rep_cnt  <= '0;
            moved    <= 1'b0;
        end else begin
            x_pos    <= x_nxt;
            held     <= held_nxt;
            brk_pend <= brk_nxt;
            ext_pend <= ext_nxt;
            rep_cnt  <= rep_nxt;
            moved    <= moved_nxt;
        end
    end

    assign at_left  = (x_pos == '0);
    assign at_right = (x_pos == LAST_POS);

endmodule

// File: tb/tb_aim_arrow_ctrl.sv
module tb_aim_arrow_ctrl;

    logic       CLOCK_50 = 1'b0;
    logic       reset, scan_valid, tick, lock, recenter;
    logic [7:0] scan_code;

    logic [3:0] x0, x1;
    logic       al0, ar0, mv0, al1, ar1, mv1;
    logic [1:0] h0, h1;

    int checks = 0;
    int errors = 0;

    always #5 CLOCK_50 = ~CLOCK_50;

    aim_arrow_ctrl #(.WRAP(0)) dut0 (
        .CLOCK_50(CLOCK_50), .reset(reset), .scan_code(scan_code),
        .scan_valid(scan_valid), .tick(tick), .lock(lock), .recenter(recenter),
        .x_pos(x0), .at_left(al0), .at_right(ar0), .moved(mv0), .held(h0)
    );

    aim_arrow_ctrl #(.WRAP(1)) dut1 (
        .CLOCK_50(CLOCK_50), .reset(reset), .scan_code(scan_code),
        .scan_valid(scan_valid), .tick(tick), .lock(lock), .recenter(recenter),
        .x_pos(x1), .at_left(al1), .at_right(ar1), .moved(mv1), .held(h1)
    );

    // ---------------- behavioural reference (index 0: saturate, 1: wrap) ----
    int m_x[2];
    int m_cnt[2];
    bit m_hl[2], m_hr[2], m_brk[2], m_ext[2], m_mv[2];
    bit started = 1'b0;

    task automatic model_step(input int w);
        bit pl, pr;
        int dir, np, nh;
        pl = 0; pr = 0; dir = 0;
        if (reset) begin
            m_x[w] = 5; m_cnt[w] = 0; m_mv[w] = 0;
            m_hl[w] = 0; m_hr[w] = 0; m_brk[w] = 0; m_ext[w] = 0;
            return;
        end
        if (scan_valid) begin
            if (scan_code == 8'hF0) m_brk[w] = 1;
            else if (scan_code == 8'hE0) m_ext[w] = 1;
            else begin
                if (!m_ext[w]) begin
                    if (m_brk[w]) begin
                        if (scan_code == 8'h1C) m_hl[w] = 0;
                        if (scan_code == 8'h23) m_hr[w] = 0;
                    end else begin
                        if (scan_code == 8'h1C && !m_hl[w]) begin m_hl[w] = 1; pl = 1; end
                        if (scan_code == 8'h23 && !m_hr[w]) begin m_hr[w] = 1; pr = 1; end
                    end
                end
                m_brk[w] = 0; m_ext[w] = 0;
            end
        end
        nh = int'(m_hl[w]) + int'(m_hr[w]);
        if (lock || nh != 1) m_cnt[w] = 0;
        else if (pl || pr) begin
            m_cnt[w] = 8;
            dir = m_hr[w] ? 1 : -1;
        end else if (tick) begin
            if (m_cnt[w] == 1) begin
                dir = m_hr[w] ? 1 : -1;
                m_cnt[w] = 3;
            end else if (m_cnt[w] > 1) m_cnt[w] = m_cnt[w] - 1;
            else m_cnt[w] = 8;
        end
        m_mv[w] = 0;
        if (dir != 0) begin
            np = m_x[w] + dir;
            if (np < 0) np = (w == 1) ? 9 : 0;
            else if (np > 9) np = (w == 1) ? 0 : 9;
            m_mv[w] = (np != m_x[w]);
            m_x[w] = np;
        end
        if (recenter) begin
            m_x[w] = 5;
            m_mv[w] = 0;
            if (!lock && nh == 1) m_cnt[w] = 8;
        end
    endtask

    always @(posedge CLOCK_50) begin
        for (int w = 0; w < 2; w++) model_step(w);
        started = 1'b1;
    end

    task automatic compare(input int w, input logic [3:0] x, input logic al,
                           input logic ar, input logic mv, input logic [1:0] h);
        logic [8:0] act, exp;
        act = {x, al, ar, mv, h};
        exp = {4'(m_x[w]), m_x[w] == 0, m_x[w] == 9, m_mv[w], m_hr[w], m_hl[w]};
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL model_w%0d t=%0t actual x=%0d l=%b r=%b mv=%b held=%b required x=%0d l=%b r=%b mv=%b held=%b",
                     w, $time, act[8:5], act[4], act[3], act[2], act[1:0],
                     exp[8:5], exp[4], exp[3], exp[2], exp[1:0]);
        end
    endtask

    always @(negedge CLOCK_50) begin
        if (started) begin
            compare(0, x0, al0, ar0, mv0, h0);
            compare(1, x1, al1, ar1, mv1, h1);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic lit(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic cyc(input logic sv, input logic [7:0] code, input logic tk, input logic rc);
        scan_valid = sv; scan_code = code; tick = tk; recenter = rc;
        @(posedge CLOCK_50); #1;
        scan_valid = 1'b0; tick = 1'b0; recenter = 1'b0;
    endtask

    task automatic key(input logic [7:0] code);
        cyc(1'b1, code, 1'b0, 1'b0);
    endtask

    task automatic brk(input logic [7:0] code);
        cyc(1'b1, 8'hF0, 1'b0, 1'b0);
        cyc(1'b1, code, 1'b0, 1'b0);
    endtask

    task automatic tk1();
        cyc(1'b0, 8'h00, 1'b1, 1'b0);
    endtask

    initial begin
        logic       sv, tk, rc;
        logic [7:0] c;
        int         r;

        reset = 1'b1; scan_valid = 1'b0; scan_code = 8'h00;
        tick = 1'b0; lock = 1'b0; recenter = 1'b0;
        @(posedge CLOCK_50); #1;
        @(posedge CLOCK_50); #1;
        reset = 1'b0;
        lit("rst_x", x0, 5);
        lit("rst_held", h0, 0);
        lit("rst_moved", mv0, 0);

        // single press A: 5 -> 4, one moved pulse
        key(8'h1C);
        lit("press_a_x", x0, 4);
        lit("press_a_moved", mv0, 1);
        cyc(1'b0, 8'h00, 1'b0, 1'b0);
        lit("press_a_moved_once", mv0, 0);
        brk(8'h1C);
        lit("release_a_held", h0, 0);
        lit("release_a_x", x0, 4);

        // hold D from 6, repeat timing and saturation vs wrap
        key(8'h23); brk(8'h23); key(8'h23);
        lit("hold_d_x", x0, 6);
        lit("hold_d_held", h0, 2);
        for (int i = 1; i <= 17; i++) begin
            tk1();
            if (i == 7)  lit("rep_tick7_x", x0, 6);
            if (i == 8)  lit("rep_tick8_x", x0, 7);
            if (i == 10) lit("rep_tick10_x", x0, 7);
            if (i == 11) lit("rep_tick11_x", x0, 8);
            if (i == 14) lit("rep_tick14_x", x0, 9);
            if (i == 17) begin
                lit("sat_x", x0, 9);
                lit("sat_moved", mv0, 0);
                lit("sat_at_right", ar0, 1);
                lit("wrap_r_x", x1, 0);
                lit("wrap_r_moved", mv1, 1);
            end
        end
        brk(8'h23);

        // wrap instance: 0 -> 9 on A, 9 -> 0 on D
        key(8'h1C);
        lit("wrap_l_x", x1, 9);
        lit("wrap_l_moved", mv1, 1);
        lit("sat_inst_l_x", x0, 8);
        brk(8'h1C);
        key(8'h23);
        lit("wrap_r2_x", x1, 0);
        brk(8'h23);

        // both held: no steps; release A -> reload on next tick, step 8 later
        key(8'h1C);
        key(8'h23);
        lit("both_held", h0, 3);
        lit("both_x", x0, 8);
        for (int i = 0; i < 10; i++) tk1();
        lit("both_ticks_x", x0, 8);
        brk(8'h1C);
        lit("one_left_held", h0, 2);
        for (int i = 0; i < 8; i++) tk1();
        lit("reload_8_x", x0, 8);
        tk1();
        lit("reload_9_x", x0, 9);
        brk(8'h23);

        // extended prefix ignored, typematic make ignored
        key(8'hE0); key(8'h1C);
        lit("ext_held", h0, 0);
        lit("ext_x", x0, 9);
        key(8'h1C);
        key(8'h1C);
        lit("typematic_x", x0, 8);
        lit("typematic_moved", mv0, 0);
        brk(8'h1C);

        // lock freezes position but held still tracks
        lock = 1'b1;
        key(8'h1C);
        lit("lock_x", x0, 8);
        lit("lock_held", h0, 1);
        brk(8'h1C);
        lock = 1'b0;

        // walk to 2, then recenter
        for (int i = 0; i < 6; i++) begin key(8'h1C); brk(8'h1C); end
        lit("walk_x", x0, 2);
        cyc(1'b0, 8'h00, 1'b0, 1'b1);
        lit("recenter_x", x0, 5);
        lit("recenter_moved", mv0, 0);

        // reset between F0 and 1C discards the break prefix
        key(8'hF0);
        reset = 1'b1;
        cyc(1'b0, 8'h00, 1'b0, 1'b0);
        reset = 1'b0;
        key(8'h1C);
        lit("rst_brk_x", x0, 4);
        lit("rst_brk_held", h0, 1);
        brk(8'h1C);

        // press coincident with tick: press wins, delay starts full
        cyc(1'b1, 8'h23, 1'b1, 1'b0);
        lit("press_tick_x", x0, 5);
        for (int i = 0; i < 7; i++) tk1();
        lit("press_tick_7_x", x0, 5);
        tk1();
        lit("press_tick_8_x", x0, 6);
        brk(8'h23);

        // randomized traffic against the model
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(63) == 0) lock = ~lock;
            sv = ($urandom_range(3) == 0);
            r  = $urandom_range(9);
            c  = (r < 3) ? 8'h1C : (r < 6) ? 8'h23 : (r < 8) ? 8'hF0 :
                 (r == 8) ? 8'hE0 : 8'($urandom);
            tk = !sv && ($urandom_range(2) == 0);
            rc = !lock && ($urandom_range(40) == 0);
            reset = ($urandom_range(700) == 0);
            cyc(sv, c, tk, rc);
            reset = 1'b0;
        end

        @(negedge CLOCK_50);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
